// File: rtl/axi_burst_mem_interface_if.sv
// AXI4 channel bundle between a crossbar master and the burst memory front-end.
interface axi_burst_mem_interface_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 10
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                aw_valid;
  logic                aw_ready;

  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic                w_valid;
  logic                w_ready;

  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;

  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                ar_valid;
  logic                ar_ready;

  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic                r_valid;
  logic                r_ready;

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  w_data, w_strb, w_last, w_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  r_ready,
    output aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid
  );

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output w_data, w_strb, w_last, w_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output r_ready,
    input  aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid
  );
endinterface

// File: rtl/axi_burst_mem_interface.sv
// AXI4 burst slave driving a one-cycle-latency memory request port.
// state   | meaning
// IDLE    | arbitrate AW/AR, latch burst context
// RD_REQ  | issue read for current beat (suppressed if out of range)
// RD_DATA | present R beat, hold until r_ready
// WR_DATA | accept W beats, write in-range ones
// WR_RESP | present B until b_ready
module axi_burst_mem_interface #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] SIZE_BYTES = AXI_ADDR_WIDTH'(64'h10000)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  axi_burst_mem_interface_if.slave      axi,
  output logic                          en_o,
  output logic                          we_o,
  output logic [AXI_ADDR_WIDTH-1:0]     address_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   be_o,
  output logic [AXI_DATA_WIDTH-1:0]     data_o,
  input  logic [AXI_DATA_WIDTH-1:0]     data_i
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH/8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(STRB_W-1);
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(STRB_W);
  localparam logic [1:0] BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_e;

  state_e                    state_q, state_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d, beat_q, beat_d;
  logic [1:0]                burst_q, burst_d;
  logic                      err_q, err_d;
  logic                      last_wr_q, last_wr_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      rfirst_q, rfirst_d;

  logic [AXI_ADDR_WIDTH:0]   range_off;
  logic                      in_range, last_beat, grant_wr;
  logic [AXI_ADDR_WIDTH-1:0] addr_next;
  logic [AXI_DATA_WIDTH-1:0] rd_word;

  // Borrow-extended subtraction keeps the window test free of constant compares.
  assign range_off = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign in_range  = !range_off[AXI_ADDR_WIDTH] && (range_off[AXI_ADDR_WIDTH-1:0] < SIZE_BYTES);
  assign last_beat = (beat_q == len_q);
  assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + BEAT_BYTES;
  assign grant_wr  = axi.aw_valid && (!axi.ar_valid || !last_wr_q);
  // Memory data is only valid on RD_DATA entry; afterwards replay the captured word.
  assign rd_word   = rfirst_q ? (in_range ? data_i : '0) : rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      last_wr_q <= 1'b0;
      rdata_q   <= '0;
      rfirst_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      last_wr_q <= last_wr_d;
      rdata_q   <= rdata_d;
      rfirst_q  <= rfirst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    err_d     = err_q;
    last_wr_d = last_wr_q;
    rdata_d   = rdata_q;
    rfirst_d  = 1'b0;

    axi.aw_ready = 1'b0;
    axi.ar_ready = 1'b0;
    axi.w_ready  = 1'b0;
    axi.b_valid  = 1'b0;
    axi.b_id     = '0;
    axi.b_resp   = RESP_OKAY;
    axi.r_valid  = 1'b0;
    axi.r_id     = '0;
    axi.r_data   = '0;
    axi.r_resp   = RESP_OKAY;
    axi.r_last   = 1'b0;

    en_o      = 1'b0;
    we_o      = 1'b0;
    address_o = '0;
    be_o      = '0;
    data_o    = '0;

    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          axi.aw_ready = 1'b1;
          id_d      = axi.aw_id;
          addr_d    = axi.aw_addr & ALIGN_MASK;
          len_d     = axi.aw_len;
          burst_d   = axi.aw_burst;
          beat_d    = '0;
          err_d     = 1'b0;
          last_wr_d = 1'b1;
          state_d   = WR_DATA;
        end else if (axi.ar_valid) begin
          axi.ar_ready = 1'b1;
          id_d      = axi.ar_id;
          addr_d    = axi.ar_addr & ALIGN_MASK;
          len_d     = axi.ar_len;
          burst_d   = axi.ar_burst;
          beat_d    = '0;
          err_d     = 1'b0;
          last_wr_d = 1'b0;
          state_d   = RD_REQ;
        end
      end
      RD_REQ: begin
        if (in_range) begin
          en_o      = 1'b1;
          address_o = addr_q;
          be_o      = '1;
        end
        rfirst_d = 1'b1;
        state_d  = RD_DATA;
      end
      RD_DATA: begin
        rdata_d      = rd_word;
        axi.r_valid  = 1'b1;
        axi.r_id     = id_q;
        axi.r_data   = rd_word;
        axi.r_resp   = in_range ? RESP_OKAY : RESP_SLVERR;
        axi.r_last   = last_beat;
        if (axi.r_ready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_next;
            state_d = RD_REQ;
          end
        end
      end
      WR_DATA: begin
        axi.w_ready = 1'b1;
        if (axi.w_valid) begin
          if (in_range) begin
            en_o      = 1'b1;
            we_o      = 1'b1;
            address_o = addr_q;
            be_o      = axi.w_strb;
            data_o    = axi.w_data;
          end else begin
            err_d = 1'b1;
          end
          addr_d = addr_next;
          if (last_beat) state_d = WR_RESP;
          else           beat_d  = beat_q + 8'd1;
        end
      end
      WR_RESP: begin
        axi.b_valid = 1'b1;
        axi.b_id    = id_q;
        axi.b_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (axi.b_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef SYNTHESIS
  function automatic logic crosses_4k(input logic [AXI_ADDR_WIDTH-1:0] a, input logic [7:0] len);
    logic [AXI_ADDR_WIDTH-1:0] last_byte;
    last_byte = (a & ALIGN_MASK) + (AXI_ADDR_WIDTH'(len) << OFF_W);
    return a[AXI_ADDR_WIDTH-1:12] != last_byte[AXI_ADDR_WIDTH-1:12];
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (axi.aw_valid && axi.aw_ready) begin
        assert (axi.aw_burst != BURST_WRAP && axi.aw_size == 3'(OFF_W))
          else $error("unsupported AW burst type or size");
        assert (!(axi.aw_burst == BURST_INCR && crosses_4k(axi.aw_addr, axi.aw_len)))
          else $error("AW INCR burst crosses a 4KB boundary");
      end
      if (axi.ar_valid && axi.ar_ready) begin
        assert (axi.ar_burst != BURST_WRAP && axi.ar_size == 3'(OFF_W))
          else $error("unsupported AR burst type or size");
        assert (!(axi.ar_burst == BURST_INCR && crosses_4k(axi.ar_addr, axi.ar_len)))
          else $error("AR INCR burst crosses a 4KB boundary");
      end
      if (state_q == WR_DATA && axi.w_valid)
        assert (axi.w_last == last_beat) else $error("w_last disagrees with beat count");
    end
  end
`endif
endmodule

// File: tb/tb_axi_burst_mem_interface.sv
// Scoreboard bench: expected memory requests, R beats, B responses and grants are
// queued as stimulus is driven and compared as the DUT produces them.
module tb_axi_burst_mem_interface;
  localparam logic [63:0] BASE = 64'h0;
  localparam logic [63:0] SIZE = 64'h800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_burst_mem_interface_if #(.ADDR_W(64), .DATA_W(64), .ID_W(10)) axi ();

  logic        en, we;
  logic [63:0] addr_o, data_o, data_i;
  logic [7:0]  be;

  axi_burst_mem_interface #(
    .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10),
    .BASE_ADDR(BASE), .SIZE_BYTES(SIZE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .axi(axi),
    .en_o(en), .we_o(we), .address_o(addr_o), .be_o(be), .data_o(data_o), .data_i(data_i)
  );

  typedef struct { logic we; logic [63:0] addr; logic [7:0] be; logic [63:0] data; } req_s;
  typedef struct { logic [9:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_s;
  typedef struct { logic [9:0] id; logic [1:0] resp; } b_s;

  req_s exp_req[$];
  r_s   exp_r[$];
  b_s   exp_b[$];
  logic exp_grant[$];
  logic [63:0] wr_data_q[$];
  logic [7:0]  wr_strb_q[$];
  logic [63:0] mem [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Initial contents of every word, so untouched locations still carry distinct data.
  function automatic logic [63:0] pat(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
  endfunction

  function automatic logic in_win(input logic [63:0] a);
    return (a >= BASE) && (a - BASE < SIZE);
  endfunction

  // Memory behind the DUT: writes with byte enables, read data one cycle after request.
  logic [63:0] mem_w;
  always @(posedge clk) begin
    data_i <= {$urandom, $urandom};
    if (en && !rst) begin
      if (we) begin
        mem_w = mem.exists(addr_o) ? mem[addr_o] : pat(addr_o);
        for (int i = 0; i < 8; i++) if (be[i]) mem_w[i*8 +: 8] = data_o[i*8 +: 8];
        mem[addr_o] = mem_w;
      end else begin
        data_i <= mem.exists(addr_o) ? mem[addr_o] : pat(addr_o);
      end
    end
  end

  req_s        e_req;
  r_s          e_r;
  b_s          e_b;
  logic        r_stall = 1'b0;
  logic [63:0] r_prev_data;
  logic        r_prev_last;

  always @(negedge clk) begin
    if (rst) begin
      r_stall = 1'b0;
    end else begin
      if (en) begin
        if (exp_req.size() == 0) check("req_extra", en, 1'b0);
        else begin
          e_req = exp_req.pop_front();
          check("req_we", we, e_req.we);
          check("req_addr", addr_o, e_req.addr);
          check("req_be", be, e_req.be);
          if (e_req.we) check("req_data", data_o, e_req.data);
        end
      end
      if (r_stall) begin
        check("r_hold_valid", axi.r_valid, 1'b1);
        check("r_hold_data", axi.r_data, r_prev_data);
        check("r_hold_last", axi.r_last, r_prev_last);
      end
      if (axi.r_valid && axi.r_ready) begin
        if (exp_r.size() == 0) check("r_extra", axi.r_valid, 1'b0);
        else begin
          e_r = exp_r.pop_front();
          check("r_id", axi.r_id, e_r.id);
          check("r_data", axi.r_data, e_r.data);
          check("r_resp", axi.r_resp, e_r.resp);
          check("r_last", axi.r_last, e_r.last);
        end
      end
      r_stall     = axi.r_valid && !axi.r_ready;
      r_prev_data = axi.r_data;
      r_prev_last = axi.r_last;
      if (axi.b_valid && axi.b_ready) begin
        if (exp_b.size() == 0) check("b_extra", axi.b_valid, 1'b0);
        else begin
          e_b = exp_b.pop_front();
          check("b_id", axi.b_id, e_b.id);
          check("b_resp", axi.b_resp, e_b.resp);
        end
      end
      if (axi.aw_ready || axi.ar_ready) begin
        if (exp_grant.size() == 0) check("grant_extra", axi.aw_ready | axi.ar_ready, 1'b0);
        else check("grant_is_write", axi.aw_ready, exp_grant.pop_front());
      end
    end
  end

  // All tasks start and end 1ns after a rising edge.
  task automatic do_write(input logic [9:0] id, input logic [63:0] a, input logic [7:0] len,
                          input logic [1:0] burst);
    logic got, err;
    int t;
    logic [63:0] cur, old;
    axi.aw_valid = 1'b1; axi.aw_id = id; axi.aw_addr = a; axi.aw_len = len;
    axi.aw_size = 3'd3; axi.aw_burst = burst;
    t = 0;
    do begin @(negedge clk); got = axi.aw_ready; @(posedge clk); #1; t++; end
    while (!got && t < 200);
    axi.aw_valid = 1'b0;
    if (!got) check("aw_timeout", got, 1'b1);
    cur = a & ~64'h7;
    err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      axi.w_valid = 1'b1; axi.w_data = wr_data_q[i]; axi.w_strb = wr_strb_q[i];
      axi.w_last = (i == int'(len));
      if (in_win(cur)) begin
        exp_req.push_back(req_s'{1'b1, cur, wr_strb_q[i], wr_data_q[i]});
        old = ref_mem.exists(cur) ? ref_mem[cur] : pat(cur);
        for (int k = 0; k < 8; k++) if (wr_strb_q[i][k]) old[k*8 +: 8] = wr_data_q[i][k*8 +: 8];
        ref_mem[cur] = old;
      end else err = 1'b1;
      t = 0;
      do begin @(negedge clk); got = axi.w_ready; @(posedge clk); #1; t++; end
      while (!got && t < 200);
      if (!got) check("w_timeout", got, 1'b1);
      if (burst == 2'b01) cur += 64'd8;
    end
    axi.w_valid = 1'b0; axi.w_last = 1'b0;
    exp_b.push_back(b_s'{id, err ? 2'b10 : 2'b00});
    t = 0;
    do begin
      axi.b_ready = 1'($urandom_range(0, 1));
      @(negedge clk); got = axi.b_valid && axi.b_ready; @(posedge clk); #1; t++;
    end while (!got && t < 200);
    axi.b_ready = 1'b0;
    if (!got) check("b_timeout", got, 1'b1);
  endtask

  task automatic ar_send(input logic [9:0] id, input logic [63:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
    logic got;
    int t;
    logic [63:0] cur;
    axi.ar_valid = 1'b1; axi.ar_id = id; axi.ar_addr = a; axi.ar_len = len;
    axi.ar_size = 3'd3; axi.ar_burst = burst;
    t = 0;
    do begin @(negedge clk); got = axi.ar_ready; @(posedge clk); #1; t++; end
    while (!got && t < 200);
    axi.ar_valid = 1'b0;
    if (!got) check("ar_timeout", got, 1'b1);
    cur = a & ~64'h7;
    for (int i = 0; i <= int'(len); i++) begin
      if (in_win(cur)) begin
        exp_req.push_back(req_s'{1'b0, cur, 8'hFF, 64'h0});
        exp_r.push_back(r_s'{id, ref_mem.exists(cur) ? ref_mem[cur] : pat(cur), 2'b00, i == int'(len)});
      end else begin
        exp_r.push_back(r_s'{id, 64'h0, 2'b10, i == int'(len)});
      end
      if (burst == 2'b01) cur += 64'd8;
    end
  endtask

  task automatic do_read(input logic [9:0] id, input logic [63:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
    int n, t;
    ar_send(id, a, len, burst);
    n = 0; t = 0;
    while (n <= int'(len) && t < 400) begin
      axi.r_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (axi.r_valid && axi.r_ready) n++;
      @(posedge clk); #1; t++;
    end
    axi.r_ready = 1'b0;
    if (n <= int'(len)) check("r_timeout", n, int'(len) + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic got;
    axi.aw_valid = 0; axi.aw_id = 0; axi.aw_addr = 0; axi.aw_len = 0; axi.aw_size = 0; axi.aw_burst = 0;
    axi.w_valid = 0; axi.w_data = 0; axi.w_strb = 0; axi.w_last = 0; axi.b_ready = 0;
    axi.ar_valid = 0; axi.ar_id = 0; axi.ar_addr = 0; axi.ar_len = 0; axi.ar_size = 0; axi.ar_burst = 0;
    axi.r_ready = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_aw_ready", axi.aw_ready, 1'b0);
    check("rst_ar_ready", axi.ar_ready, 1'b0);
    check("rst_w_ready", axi.w_ready, 1'b0);
    check("rst_b_valid", axi.b_valid, 1'b0);
    check("rst_r_valid", axi.r_valid, 1'b0);
    check("rst_en", en, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_addr", addr_o, 64'h0);
    check("rst_be", be, 8'h0);
    check("rst_data", data_o, 64'h0);
    @(posedge clk); #1;

    // single write then read back
    exp_grant.push_back(1'b1);
    wr_data_q = '{64'hDEADBEEF_CAFEF00D}; wr_strb_q = '{8'hFF};
    do_write(10'd3, 64'h10, 8'd0, 2'b01);
    exp_grant.push_back(1'b0);
    do_read(10'd3, 64'h10, 8'd0, 2'b01);

    // INCR read burst with random back-pressure
    exp_grant.push_back(1'b0);
    do_read(10'd5, 64'h100, 8'd3, 2'b01);

    // FIXED write burst merging two half-word strobes
    exp_grant.push_back(1'b1);
    wr_data_q = '{64'h1111_1111_AAAA_AAAA, 64'hBBBB_BBBB_2222_2222}; wr_strb_q = '{8'h0F, 8'hF0};
    do_write(10'd7, 64'h200, 8'd1, 2'b00);
    exp_grant.push_back(1'b0);
    do_read(10'd7, 64'h200, 8'd0, 2'b01);

    // window edge: second beat falls outside, then a fully outside read
    exp_grant.push_back(1'b1);
    wr_data_q = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}; wr_strb_q = '{8'hFF, 8'hFF};
    do_write(10'd1, 64'h7F8, 8'd1, 2'b01);
    exp_grant.push_back(1'b0);
    do_read(10'd2, 64'h2000, 8'd0, 2'b01);
    exp_grant.push_back(1'b0);
    do_read(10'd2, 64'h7F8, 8'd0, 2'b01);

    // contending AW and AR: last grant was a read, so write goes first
    exp_grant.push_back(1'b1); exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1); exp_grant.push_back(1'b0);
    fork
      begin
        wr_data_q = '{64'h3030_3030_3030_3030}; wr_strb_q = '{8'hFF};
        do_write(10'd11, 64'h300, 8'd0, 2'b01);
        wr_data_q = '{64'h3131_3131_3131_3131}; wr_strb_q = '{8'hFF};
        do_write(10'd12, 64'h308, 8'd0, 2'b01);
      end
      begin
        do_read(10'd13, 64'h310, 8'd1, 2'b01);
        do_read(10'd14, 64'h320, 8'd0, 2'b01);
      end
    join

    // reset during second beat of a 4-beat read
    exp_grant.push_back(1'b0);
    ar_send(10'd6, 64'h140, 8'd3, 2'b01);
    axi.r_ready = 1'b1;
    t = 0;
    do begin @(negedge clk); got = axi.r_valid; @(posedge clk); #1; t++; end
    while (!got && t < 50);
    if (!got) check("r_first_timeout", got, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    axi.r_ready = 1'b0;
    exp_req.delete();
    exp_r.delete();
    @(negedge clk);
    check("abort_r_valid", axi.r_valid, 1'b0);
    check("abort_en", en, 1'b0);
    check("abort_b_valid", axi.b_valid, 1'b0);
    @(posedge clk); #1;
    exp_grant.push_back(1'b0);
    do_read(10'd9, 64'h120, 8'd1, 2'b01);

    repeat (3) @(posedge clk);
    #1;
    check("left_req", exp_req.size(), 0);
    check("left_r", exp_r.size(), 0);
    check("left_b", exp_b.size(), 0);
    check("left_grant", exp_grant.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
